// File: rtl/clint_seq.sv
// Core-local trap sequencer: detects ecall/ebreak/mret/interrupts, stalls the pipeline,
// writes mepc/mstatus/mcause through the CLINT CSR port, then redirects fetch.
module clint_seq #(
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3,
    parameter logic [31:0] INT_CAUSE    = 32'h8000_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  int_flag_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] raddr_o,
    output logic [31:0] data_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        ASSERT,
        MRET_W,
        MRET_ASSERT
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] cause_q;

    logic is_ecall, is_ebreak, is_mret, is_async, is_sync, trigger;

    // Trigger decode only matters in IDLE; everything is ignored mid-sequence.
    assign is_ecall  = (state == IDLE) && (inst_i == INST_ECALL);
    assign is_ebreak = (state == IDLE) && (inst_i == INST_EBREAK);
    assign is_mret   = (state == IDLE) && (inst_i == INST_MRET);
    assign is_async  = (state == IDLE) && (int_flag_i != 8'd0) && global_int_en_i && !hold_flag_i;
    assign is_sync   = is_ecall || is_ebreak;
    assign trigger   = is_sync || is_mret || is_async;

    assign hold_flag_o = (state != IDLE) || trigger;
    assign raddr_o     = 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= 32'd0;
            cause_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_sync) begin
                        state   <= W_MEPC;
                        pc_q    <= inst_addr_i;
                        cause_q <= is_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
                    end else if (is_mret) begin
                        state <= MRET_W;
                    end else if (is_async) begin
                        // Interrupt returns to wherever execute was heading this cycle.
                        state   <= W_MEPC;
                        pc_q    <= jump_flag_i ? jump_addr_i : inst_addr_i;
                        cause_q <= INT_CAUSE;
                    end
                end
                W_MEPC:      state <= W_MSTATUS;
                W_MSTATUS:   state <= W_MCAUSE;
                W_MCAUSE:    state <= ASSERT;
                MRET_W:      state <= MRET_ASSERT;
                ASSERT:      state <= IDLE;
                MRET_ASSERT: state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // CSR port and redirect are pure functions of the current state.
    always_comb begin
        we_o         = 1'b0;
        waddr_o      = 32'd0;
        data_o       = 32'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'd0;
        case (state)
            W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = CSR_MEPC;
                data_o  = pc_q;
            end
            W_MSTATUS: begin
                we_o    = 1'b1;
                waddr_o = CSR_MSTATUS;
                data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                           1'b0, csr_mstatus_i[2:0]};
            end
            W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = CSR_MCAUSE;
                data_o  = cause_q;
            end
            ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
            end
            MRET_W: begin
                we_o    = 1'b1;
                waddr_o = CSR_MSTATUS;
                data_o  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                           csr_mstatus_i[7], csr_mstatus_i[2:0]};
            end
            MRET_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clint_seq.sv
// Scoreboard bench for clint_seq: stimulus pushes expected CSR writes/redirects with
// their cycle stamps; a negedge monitor pops and compares whatever the DUT presents.
module tb_clint_seq;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] A_MSTATUS = 32'h300;
    localparam logic [31:0] A_MEPC    = 32'h341;
    localparam logic [31:0] A_MCAUSE  = 32'h342;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_flag_i;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_flag_i, hold_flag_i;
    logic        we_o, hold_flag_o, int_assert_o;
    logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;

    // CSR file contents as the reference sees them
    logic [31:0] mstatus_m, mepc_m, mtvec_m;

    clint_seq dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .global_int_en_i(mstatus_m[3]),
        .csr_mtvec_i(mtvec_m), .csr_mepc_i(mepc_m), .csr_mstatus_i(mstatus_m),
        .we_o(we_o), .waddr_o(waddr_o), .raddr_o(raddr_o), .data_o(data_o),
        .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        is_assert;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, req);
        end
    endtask

    // mstatus after trap entry: MPIE takes MIE, MIE cleared
    function automatic logic [31:0] trap_ms(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[7] = ms[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // mstatus after mret: MIE takes MPIE, MPIE set
    function automatic logic [31:0] mret_ms(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

    // Monitor: every cycle either matches the next queued event or shows an idle port.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (we_o === 1'b1 || int_assert_o === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event cyc=%0d we=%0b waddr=0x%0h data=0x%08h assert=%0b addr=0x%08h",
                             cyc, we_o, waddr_o, data_o, int_assert_o, int_addr_o);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || int_assert_o !== e.is_assert || we_o !== !e.is_assert ||
                        (e.is_assert ? (int_addr_o !== e.data || waddr_o !== 32'd0 || data_o !== 32'd0)
                                     : (waddr_o !== e.addr || data_o !== e.data || int_addr_o !== 32'd0))) begin
                        fails++;
                        $display("FAIL event cyc=%0d we=%0b waddr=0x%0h data=0x%08h assert=%0b addr=0x%08h required cyc=%0d assert=%0b waddr=0x%0h data=0x%08h",
                                 cyc, we_o, waddr_o, data_o, int_assert_o, int_addr_o,
                                 e.cyc, e.is_assert, e.addr, e.data);
                    end
                end
            end else begin
                check("idle_port", waddr_o | data_o | int_addr_o | raddr_o, 32'd0);
            end
        end
    end

    function automatic logic [31:0] pick_inst();
        case ($urandom_range(0, 4))
            0: return ECALL;
            1: return EBREAK;
            2: return MRET;
            default: return $urandom;
        endcase
    endfunction

    // One IDLE detection cycle plus however many sequence cycles the rules imply.
    task automatic step(input logic rand_csr, input logic [31:0] inst, input logic [7:0] irq,
                        input logic hi, input logic jf, input logic [31:0] ia, input logic [31:0] ja);
        logic        sync_t, mret_t, async_t;
        logic [31:0] pc, cause;
        int unsigned n;
        int          len;
        @(posedge clk); #1;
        if (rand_csr && $urandom_range(0, 3) == 0) begin
            mstatus_m = $urandom;
            mtvec_m   = $urandom & ~32'h3;
        end
        inst_i = inst; int_flag_i = irq; hold_flag_i = hi;
        jump_flag_i = jf; inst_addr_i = ia; jump_addr_i = ja;
        n       = cyc;
        sync_t  = (inst == ECALL) || (inst == EBREAK);
        mret_t  = !sync_t && (inst == MRET);
        async_t = !sync_t && !mret_t && (irq != 8'd0) && mstatus_m[3] && !hi;
        len     = 0;
        pc      = 32'd0;
        if (sync_t || async_t) begin
            pc    = sync_t ? ia : (jf ? ja : ia);
            cause = (inst == ECALL) ? 32'd11 : (inst == EBREAK) ? 32'd3 : 32'h8000_0007;
            q.push_back('{n + 1, 1'b0, A_MEPC, pc});
            q.push_back('{n + 2, 1'b0, A_MSTATUS, trap_ms(mstatus_m)});
            q.push_back('{n + 3, 1'b0, A_MCAUSE, cause});
            q.push_back('{n + 4, 1'b1, 32'd0, mtvec_m});
            len = 4;
        end else if (mret_t) begin
            q.push_back('{n + 1, 1'b0, A_MSTATUS, mret_ms(mstatus_m)});
            q.push_back('{n + 2, 1'b1, 32'd0, mepc_m});
            len = 2;
        end
        #3 check("hold_detect", 32'(hold_flag_o), 32'(sync_t || mret_t || async_t));
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            inst_i = pick_inst(); int_flag_i = 8'($urandom); hold_flag_i = 1'($urandom);
            jump_flag_i = 1'($urandom); inst_addr_i = $urandom; jump_addr_i = $urandom;
            #3 check("hold_seq", 32'(hold_flag_o), 32'd1);
        end
        if (len == 4) begin
            mepc_m    = pc;
            mstatus_m = trap_ms(mstatus_m);
        end else if (len == 2) begin
            mstatus_m = mret_ms(mstatus_m);
        end
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1; int_flag_i = 8'd0; inst_i = 32'd0; inst_addr_i = 32'd0;
        jump_flag_i = 1'b0; jump_addr_i = 32'd0; hold_flag_i = 1'b0;
        mstatus_m = 32'h8; mepc_m = 32'd0; mtvec_m = 32'h200;
        repeat (3) @(posedge clk);
        #1;
        check("reset_we", 32'(we_o), 32'd0);
        check("reset_hold", 32'(hold_flag_o), 32'd0);
        check("reset_assert", 32'(int_assert_o), 32'd0);
        check("reset_data", waddr_o | data_o | int_addr_o, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // ecall, then a level interrupt that must not re-trap with MIE now 0
        step(1'b0, ECALL, 8'h01, 1'b0, 1'b0, 32'h100, 32'h0);
        check("mstatus_after_ecall", mstatus_m, 32'h80);
        step(1'b0, 32'h13, 8'h01, 1'b0, 1'b1, 32'h104, 32'h340);
        // mret restores MIE, then the interrupt is taken at the jump target
        mepc_m = 32'h104;
        step(1'b0, MRET, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h13, 8'h01, 1'b0, 1'b1, 32'h200, 32'h340);
        // interrupt deferred by external hold
        mstatus_m = 32'h8;
        step(1'b0, 32'h13, 8'h01, 1'b1, 1'b0, 32'h300, 32'h0);
        step(1'b0, EBREAK, 8'h00, 1'b0, 1'b0, 32'h304, 32'h0);
        step(1'b0, EBREAK, 8'h00, 1'b0, 1'b0, 32'h308, 32'h0);

        // reset in W_MSTATUS abandons the trap with no redirect
        mstatus_m = 32'h8;
        @(posedge clk); #1;
        inst_i = ECALL; inst_addr_i = 32'h500; int_flag_i = 8'd0;
        n = cyc;
        q.push_back('{n + 1, 1'b0, A_MEPC, 32'h500});
        q.push_back('{n + 2, 1'b0, A_MSTATUS, 32'h80});
        @(posedge clk); #1; inst_i = 32'd0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        #3;
        check("rst_abort_we", 32'(we_o), 32'd0);
        check("rst_abort_assert", 32'(int_assert_o), 32'd0);
        check("rst_abort_hold", 32'(hold_flag_o), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 400; i++) begin
            step(1'b1, pick_inst(), ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), $urandom, $urandom);
        end

        @(posedge clk); #1;
        inst_i = 32'd0; int_flag_i = 8'd0;
        repeat (6) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clint_seq.md
Name: clint_seq

Overview:
- Core-local trap sequencer: the only block that drives the CLINT write/read port of the CSR register file.
- Detects ecall, ebreak, mret and asserted external/timer interrupts at the execute stage.
- Holds the pipeline, then performs the required multi-cycle CSR update sequence (mepc, mstatus, mcause).
- Finally redirects fetch to mtvec (trap) or mepc (mret) via a one-cycle jump assertion.

Parameters:
- ECALL_CAUSE, 32'd11, mcause value written for ecall.
- EBREAK_CAUSE, 32'd3, mcause value written for ebreak.
- INT_CAUSE, 32'h8000_0007, mcause value written for an asynchronous interrupt.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- int_flag_i  in  8  interrupt request lines; any nonzero bit is a level request
- inst_i  in  32  instruction in execute stage
- inst_addr_i  in  32  PC of instruction in execute stage
- jump_flag_i  in  1  execute stage is taking a jump this cycle
- jump_addr_i  in  32  target of that jump
- hold_flag_i  in  1  bus/pipeline hold from elsewhere; defers async interrupts only
- global_int_en_i  in  1  mstatus.MIE from CSR file
- csr_mtvec_i  in  32  mtvec from CSR file
- csr_mepc_i  in  32  mepc from CSR file
- csr_mstatus_i  in  32  mstatus from CSR file
- we_o  out  1  CSR write enable (CLINT port)
- waddr_o  out  32  CSR write address; upper 20 bits zero
- raddr_o  out  32  CSR read address; tied to zero (unused)
- data_o  out  32  CSR write data
- hold_flag_o  out  1  stall request to pipeline control
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  32  redirect target, valid only when int_assert_o=1

Behaviour:
- Reset: all outputs 0; state=IDLE; latched pc/cause cleared. Reset asserted in any state returns to IDLE next edge; any in-progress sequence is abandoned, with no partial redirect.
- Decode, combinational, in IDLE:
  - ecall: inst_i==32'h0000_0073.
  - ebreak: inst_i==32'h0010_0073.
  - mret: inst_i==32'h3020_0073.
  - async: int_flag_i!=0 && global_int_en_i && !hold_flag_i.
- Priority: ecall/ebreak > mret > async. A losing async request is not lost; the level is re-sampled when the FSM returns to IDLE.
- Detection cycle N (IDLE):
  - hold_flag_o=1 combinationally.
  - Latch pc: inst_addr_i for sync traps; jump_addr_i if jump_flag_i, else inst_addr_i, for async.
  - Latch cause.
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET_W, MRET_ASSERT.
- Trap sequence:
  - N+1 W_MEPC: we_o=1, waddr_o=CSR_MEPC, data_o=latched pc.
  - N+2 W_MSTATUS: we_o=1, waddr_o=CSR_MSTATUS, data_o={ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]} with ms=csr_mstatus_i sampled this cycle (MPIE<=MIE, MIE<=0).
  - N+3 W_MCAUSE: we_o=1, waddr_o=CSR_MCAUSE, data_o=latched cause.
  - N+4 ASSERT: int_assert_o=1, int_addr_o=csr_mtvec_i, we_o=0.
  - N+5: IDLE.
- mret sequence:
  - N+1 MRET_W: we_o=1, waddr_o=CSR_MSTATUS, data_o={ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]} (MIE<=MPIE, MPIE<=1).
  - N+2 MRET_ASSERT: int_assert_o=1, int_addr_o=csr_mepc_i.
  - N+3: IDLE.
- hold_flag_o=1 in detection cycle and every non-IDLE state; 0 in IDLE with no trigger.
- we_o, waddr_o, data_o are 0 whenever not in a write state. int_assert_o and int_addr_o are 0 outside ASSERT/MRET_ASSERT.
- Back-to-back: a trigger present in the cycle the FSM enters IDLE is detected that same cycle. Because MIE is cleared by the trap, a still-high int_flag_i does not re-trap until software re-enables MIE.
- Inputs are ignored while not IDLE, including int_flag_i edges and new instructions.

Test Plan:
- ecall at inst_addr_i=0x100, mtvec=0x200, mstatus=0x8 -> writes mepc=0x100, mstatus=0x80, mcause=11 on N+1..N+3; N+4 int_assert_o=1, int_addr_o=0x200; hold_flag_o high N..N+4, low N+5.
- int_flag_i=0x01, MIE=1, jump_flag_i=1, jump_addr_i=0x340 -> mepc=0x340, mcause=0x8000_0007; with MIE=0, or hold_flag_i=1 -> no hold, no writes.
- mret with mstatus=0x80, mepc=0x104 -> N+1 write mstatus=0x88; N+2 int_assert_o=1, int_addr_o=0x104; back in IDLE at N+3.
- ecall and int_flag_i=0x01 same cycle, MIE=1 -> ecall sequence (mcause=11); interrupt not taken afterwards since MIE=0 after trap.
- rst=1 during W_MSTATUS -> next cycle all outputs 0, IDLE, no int_assert_o ever for that trap.
- ebreak immediately after return to IDLE -> detected in that cycle; mcause=3; hold_flag_o continuous.
